// File: rtl/spike_detector.sv
// Amplitude spike detector: rectify, threshold with hysteresis, track peak/width
// of each excursion, report on exit, then hold off for a refractory period.
module spike_detector #(
  parameter int W         = 11,
  parameter int HYST      = 8,
  parameter int REFRACT   = 16,
  parameter int MAX_WIDTH = 64,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic signed [W-1:0] x,
  input  logic        [W-2:0] thr,
  input  logic                enable,
  output logic                spike_valid,
  output logic signed [W-1:0] spike_peak,
  output logic        [7:0]   spike_width,
  output logic                spike_trunc,
  output logic    [CNT_W-1:0] spike_count,
  output logic                busy
);

  localparam int RW = $clog2(REFRACT + 1);
  localparam logic [W:0]    HYST_E = (W+1)'(HYST);
  localparam logic [7:0]    MAXW   = 8'(MAX_WIDTH);
  localparam logic [RW-1:0] RLOAD  = RW'(REFRACT);

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_REFRACT} state_t;

  state_t               state;
  logic [RW-1:0]        rcnt;
  logic signed [W-1:0]  peak_p1;
  logic        [W-2:0]  peak_mag_p1;
  logic        [7:0]    width_p1;

  // |x| with the most negative code clamped to full scale
  function automatic logic [W-2:0] abs_sat(input logic signed [W-1:0] v);
    logic signed [W-1:0] neg;
    neg = -v;
    if (v[W-1] && (v[W-2:0] == '0))
      return '1;
    return v[W-1] ? neg[W-2:0] : v[W-2:0];
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // ---- stage p0: combinational decisions on the incoming sample ----
  logic                vld_p0;
  logic        [W-2:0] mag_p0;
  logic        [W:0]   mag_hyst_p0;
  logic                enter_p0;
  logic                exit_p0;
  logic                upd_p0;
  logic        [7:0]   width_inc_p0;
  logic signed [W-1:0] peak_nx_p0;

  assign vld_p0       = in_valid && enable;
  assign mag_p0       = abs_sat(x);
  assign mag_hyst_p0  = {2'b00, mag_p0} + HYST_E;
  assign enter_p0     = mag_p0 > thr;
  assign exit_p0      = mag_hyst_p0 < {2'b00, thr};
  assign upd_p0       = mag_p0 > peak_mag_p1;
  assign width_inc_p0 = width_p1 + 8'd1;
  assign peak_nx_p0   = upd_p0 ? x : peak_p1;

  // ---- stage p1: excursion tracking registers (data path, no reset) ----
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      if (state == ST_IDLE && enter_p0) begin
        peak_p1     <= x;
        peak_mag_p1 <= mag_p0;
        width_p1    <= 8'd1;
      end else if (state == ST_ACTIVE && !exit_p0) begin
        width_p1 <= width_inc_p0;
        if (upd_p0) begin
          peak_p1     <= x;
          peak_mag_p1 <= mag_p0;
        end
      end
    end
  end

  // ---- stage p1: control FSM and registered report outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rcnt        <= '0;
      spike_valid <= 1'b0;
      spike_peak  <= '0;
      spike_width <= '0;
      spike_trunc <= 1'b0;
      spike_count <= '0;
      busy        <= 1'b0;
    end else begin
      spike_valid <= 1'b0;
      if (!enable) begin
        state <= ST_IDLE;
        rcnt  <= '0;
        busy  <= 1'b0;
      end else if (in_valid) begin
        case (state)
          ST_IDLE: begin
            if (enter_p0) begin
              state <= ST_ACTIVE;
              busy  <= 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (exit_p0) begin
              state       <= ST_REFRACT;
              rcnt        <= RLOAD;
              spike_valid <= 1'b1;
              spike_peak  <= peak_p1;
              spike_width <= width_p1;
              spike_trunc <= 1'b0;
              spike_count <= cnt_sat_inc(spike_count);
            end else if (width_inc_p0 == MAXW) begin
              state       <= ST_REFRACT;
              rcnt        <= RLOAD;
              spike_valid <= 1'b1;
              spike_peak  <= peak_nx_p0;
              spike_width <= width_inc_p0;
              spike_trunc <= 1'b1;
              spike_count <= cnt_sat_inc(spike_count);
            end
          end
          ST_REFRACT: begin
            rcnt <= rcnt - 1'b1;
            if (rcnt == RW'(1)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spike_detector.sv
// Directed bench for spike_detector: basic spike, refractory, saturation/tie,
// truncation, enable abort, asynchronous reset and stall invariance.
module tb_spike_detector;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic signed [10:0] x;
  logic        [9:0]  thr;
  logic               enable;
  logic               spike_valid;
  logic signed [10:0] spike_peak;
  logic        [7:0]  spike_width;
  logic               spike_trunc;
  logic        [15:0] spike_count;
  logic               busy;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int base;

  spike_detector #(.W(11), .HYST(8), .REFRACT(16), .MAX_WIDTH(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .thr(thr), .enable(enable),
    .spike_valid(spike_valid), .spike_peak(spike_peak), .spike_width(spike_width),
    .spike_trunc(spike_trunc), .spike_count(spike_count), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (spike_valid) pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int s);
    x        = 11'(s);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_report(input string tag, input int pk, input int wd,
                              input int tr, input int cnt);
    chk({tag, "_valid"}, int'(spike_valid), 1);
    chk({tag, "_peak"},  int'(spike_peak), pk);
    chk({tag, "_width"}, int'(spike_width), wd);
    chk({tag, "_trunc"}, int'(spike_trunc), tr);
    chk({tag, "_count"}, int'(spike_count), cnt);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; x = '0; thr = 10'd100; enable = 1'b1;
    #12;
    chk("rst_valid", int'(spike_valid), 0);
    chk("rst_count", int'(spike_count), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_peak",  int'(spike_peak), 0);
    @(negedge clk); rst = 1'b1;
    idle(2);

    // basic spike
    send(0); send(50);
    chk("basic_busy_pre", int'(busy), 0);
    send(120);
    chk("basic_busy_enter", int'(busy), 1);
    send(300); send(-400); send(200); send(95);
    chk("basic_no_early", int'(spike_valid), 0);
    send(80);
    check_report("basic", -400, 5, 0, 1);
    chk("basic_busy_refr", int'(busy), 1);

    // refractory: 15 zeros + 500 ignored, next 500 enters
    for (int i = 0; i < 15; i++) send(0);
    chk("refr_pulse_clr", int'(spike_valid), 0);
    chk("refr_busy15", int'(busy), 1);
    send(500);
    chk("refr_busy16", int'(busy), 0);
    chk("refr_no_second", pulses, 1);
    send(500);
    chk("refr_new_enter", int'(busy), 1);
    send(0);
    check_report("refr2", 500, 1, 0, 2);
    for (int i = 0; i < 16; i++) send(0);
    chk("refr2_done", int'(busy), 0);
    chk("hold_peak", int'(spike_peak), 500);

    // saturation and tie
    thr = 10'd1022;
    send(-1024); send(1023);
    chk("sat_no_early", int'(spike_valid), 0);
    send(0);
    check_report("sat", -1024, 2, 0, 3);
    for (int i = 0; i < 16; i++) send(0);

    // truncation
    thr = 10'd100;
    for (int i = 1; i <= 70; i++) begin
      send(200);
      if (i == 63) chk("trunc_pre", int'(spike_valid), 0);
      if (i == 64) check_report("trunc", 200, 64, 1, 4);
    end
    for (int i = 71; i <= 80; i++) send(200);
    chk("trunc_refr_done", int'(busy), 0);
    chk("trunc_one_pulse", pulses, 4);
    send(200);
    chk("trunc_new_enter", int'(busy), 1);
    send(0);
    check_report("after_trunc", 200, 1, 0, 5);
    for (int i = 0; i < 16; i++) send(0);

    // enable abort
    send(200); send(300);
    chk("abort_active", int'(busy), 1);
    enable = 1'b0;
    idle(1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(spike_valid), 0);
    chk("abort_count", int'(spike_count), 5);
    enable = 1'b1;
    send(0); send(0);
    chk("abort_no_report", pulses, 5);

    // asynchronous reset mid-excursion
    send(200); send(300);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_valid", int'(spike_valid), 0);
    chk("arst_peak",  int'(spike_peak), 0);
    chk("arst_width", int'(spike_width), 0);
    chk("arst_trunc", int'(spike_trunc), 0);
    chk("arst_count", int'(spike_count), 0);
    chk("arst_busy",  int'(busy), 0);
    repeat (3) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
    end
    chk("arst_hold_busy", int'(busy), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    idle(1);
    send(0); send(50); send(120); send(300); send(-400); send(200); send(95); send(80);
    check_report("post_rst", -400, 5, 0, 1);
    for (int i = 0; i < 16; i++) send(0);

    // stall invariance
    base = pulses;
    begin
      int seq[8] = '{0, 50, 120, 300, -400, 200, 95, 80};
      for (int i = 0; i < 8; i++) begin
        idle($urandom_range(0, 3));
        send(seq[i]);
        if (i == 6) chk("stall_no_early", int'(spike_valid), 0);
      end
    end
    check_report("stall", -400, 5, 0, 2);
    idle(3);
    chk("stall_one_pulse", pulses, base + 1);
    chk("stall_hold_width", int'(spike_width), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
